// File: rtl/sram_access_arbiter.sv
// Round-robin arbiter and access sequencer between a write port and a read port
// sharing one asynchronous 16-bit SRAM. Optional counters: define SRAM_ARB_STATS_EN.
//
// state      | meaning
// S_IDLE     | bus turnaround; both requests sampled, grant issued here
// S_WR       | WE_N low, DQ driven, WR_CYC cycles
// S_WR_END   | WE_N high, DQ still driven for hold, write ack
// S_RD       | OE_N low, DQ tristate, RD_WAIT cycles, capture on last
// S_RD_DONE  | OE_N high, read data valid pulse
module sram_access_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int WR_CYC  = 2,
  parameter int RD_WAIT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_dq_out,
  output logic              o_sram_dq_oe,
  input  logic [DATA_W-1:0] i_sram_dq_in,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_ce_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n,
  output logic              o_busy
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0]       o_wr_count,
  output logic [15:0]       o_rd_count
`endif
);

  localparam int MAX_CYC = (WR_CYC > RD_WAIT) ? WR_CYC : RD_WAIT;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_END,
    S_RD,
    S_RD_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              grant_wr, grant_rd, capture;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_wr_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Requester inputs are only looked at in the grant cycle.
      if (grant_wr) begin
        addr_q    <= i_wr_addr;
        data_q    <= i_wr_data;
        last_wr_q <= 1'b1;
      end
      if (grant_rd) begin
        addr_q    <= i_rd_addr;
        last_wr_q <= 1'b0;
      end
      if (capture) begin
        rd_data_q <= i_sram_dq_in;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_wr     = 1'b0;
    grant_rd     = 1'b0;
    capture      = 1'b0;
    o_sram_we_n  = 1'b1;
    o_sram_oe_n  = 1'b1;
    o_sram_dq_oe = 1'b0;
    o_wr_ack     = 1'b0;
    o_rd_valid   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Contention goes to whichever port lost the previous grant.
        if (i_wr_req && (!i_rd_req || !last_wr_q)) begin
          grant_wr = 1'b1;
          cnt_d    = WR_LOAD;
          state_d  = S_WR;
        end else if (i_rd_req) begin
          grant_rd = 1'b1;
          cnt_d    = RD_LOAD;
          state_d  = S_RD;
        end
      end
      S_WR: begin
        o_sram_we_n  = 1'b0;
        o_sram_dq_oe = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_WR_END;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WR_END: begin
        o_sram_dq_oe = 1'b1;
        o_wr_ack     = 1'b1;
        state_d      = S_IDLE;
      end
      S_RD: begin
        o_sram_oe_n = 1'b0;
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = S_RD_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RD_DONE: begin
        o_rd_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_sram_addr   = addr_q;
  assign o_sram_dq_out = data_q;
  assign o_rd_data     = rd_data_q;
  assign o_sram_ce_n   = 1'b0;
  assign o_sram_lb_n   = 1'b0;
  assign o_sram_ub_n   = 1'b0;
  assign o_busy        = (state_q != S_IDLE);

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] wr_count_q, rd_count_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_count_q <= '0;
      rd_count_q <= '0;
    end else begin
      if (o_wr_ack && (wr_count_q != 16'hFFFF)) begin
        wr_count_q <= wr_count_q + 16'd1;
      end
      if (o_rd_valid && (rd_count_q != 16'hFFFF)) begin
        rd_count_q <= rd_count_q + 16'd1;
      end
    end
  end

  assign o_wr_count = wr_count_q;
  assign o_rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Scoreboard bench for sram_access_arbiter with a behavioural SRAM model.
// Build with SRAM_ARB_STATS_EN defined to also check the access counters.
module tb_sram_access_arbiter;
  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 16;
  localparam int WR_CYC  = 2;
  localparam int RD_WAIT = 2;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } xact_t;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_wr_req = 1'b0;
  logic [ADDR_W-1:0] i_wr_addr = '0;
  logic [DATA_W-1:0] i_wr_data = '0;
  logic              o_wr_ack;
  logic              i_rd_req = 1'b0;
  logic [ADDR_W-1:0] i_rd_addr = '0;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_rd_valid;
  logic [ADDR_W-1:0] o_sram_addr;
  logic [DATA_W-1:0] o_sram_dq_out;
  logic              o_sram_dq_oe;
  logic [DATA_W-1:0] i_sram_dq_in;
  logic              o_sram_we_n, o_sram_oe_n, o_sram_ce_n, o_sram_lb_n, o_sram_ub_n;
  logic              o_busy;
`ifdef SRAM_ARB_STATS_EN
  logic [15:0]       o_wr_count, o_rd_count;
`endif

  sram_access_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_CYC(WR_CYC), .RD_WAIT(RD_WAIT)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_wr_req(i_wr_req), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .o_wr_ack(o_wr_ack),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .o_sram_addr(o_sram_addr), .o_sram_dq_out(o_sram_dq_out), .o_sram_dq_oe(o_sram_dq_oe),
    .i_sram_dq_in(i_sram_dq_in), .o_sram_we_n(o_sram_we_n), .o_sram_oe_n(o_sram_oe_n),
    .o_sram_ce_n(o_sram_ce_n), .o_sram_lb_n(o_sram_lb_n), .o_sram_ub_n(o_sram_ub_n),
    .o_busy(o_busy)
`ifdef SRAM_ARB_STATS_EN
    , .o_wr_count(o_wr_count), .o_rd_count(o_rd_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // SRAM model: unwritten locations return a pattern; read data only valid
  // once OE_N has been low for RD_WAIT-1 cycles (access time).
  function automatic logic [15:0] pat(input logic [7:0] a);
    return {a, ~a};
  endfunction

  logic [15:0] sram_mem [0:255];
  bit          sram_wr  [0:255];
  int          oe_run = 0;

  always @(posedge i_clk) begin
    if (!o_sram_we_n) begin
      sram_mem[o_sram_addr[7:0]] <= o_sram_dq_out;
      sram_wr[o_sram_addr[7:0]]  <= 1'b1;
    end
    oe_run <= o_sram_oe_n ? 0 : oe_run + 1;
  end

  assign i_sram_dq_in = (!o_sram_oe_n && oe_run >= RD_WAIT - 1)
                        ? (sram_wr[o_sram_addr[7:0]] ? sram_mem[o_sram_addr[7:0]] : pat(o_sram_addr[7:0]))
                        : 16'hDEAD;

  // Scoreboard and bus monitor
  xact_t wr_q[$];
  xact_t rd_q[$];
  bit    grant_log[$];
  bit    prev_we_n = 1'b1, prev_oe_n = 1'b1;
  int    we_low = 0, oe_low = 0;
  int    n_wr_grant = 0, n_rd_grant = 0, n_wr_ack = 0, n_rd_valid = 0;

  always @(negedge i_clk) begin
    chk("we_oe_overlap", !o_sram_we_n && !o_sram_oe_n, 1'b0);
    chk("dq_oe_during_read", o_sram_dq_oe && !o_sram_oe_n, 1'b0);
    if (!o_sram_we_n) begin
      if (prev_we_n) begin
        grant_log.push_back(1'b1);
        n_wr_grant++;
        we_low = 0;
      end
      we_low++;
      chk("wr_dq_oe", o_sram_dq_oe, 1'b1);
      chk("wr_sb_nonempty", wr_q.size() != 0, 1'b1);
      if (wr_q.size() != 0) begin
        chk("wr_addr", o_sram_addr, wr_q[0].addr);
        chk("wr_dq", o_sram_dq_out, wr_q[0].data);
      end
    end
    if (!o_sram_oe_n) begin
      if (prev_oe_n) begin
        grant_log.push_back(1'b0);
        n_rd_grant++;
        oe_low = 0;
      end
      oe_low++;
      chk("rd_sb_nonempty", rd_q.size() != 0, 1'b1);
      if (rd_q.size() != 0) chk("rd_addr", o_sram_addr, rd_q[0].addr);
    end
    if (o_wr_ack) begin
      chk("wr_strobe_len", we_low, WR_CYC);
      chk("wr_hold_dq_oe", o_sram_dq_oe, 1'b1);
      n_wr_ack++;
      if (wr_q.size() != 0) void'(wr_q.pop_front());
    end
    if (o_rd_valid) begin
      chk("rd_oe_len", oe_low, RD_WAIT);
      chk("rd_valid_sb_nonempty", rd_q.size() != 0, 1'b1);
      if (rd_q.size() != 0) begin
        chk("rd_data", o_rd_data, rd_q[0].data);
        void'(rd_q.pop_front());
      end
      n_rd_valid++;
    end
    prev_we_n = o_sram_we_n;
    prev_oe_n = o_sram_oe_n;
  end

  // Drivers: called at a negedge; leave req high when hold is set so the
  // next call can chain a back-to-back access.
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input bit drop_early, input bit scramble, input bit hold,
                          output int lat);
    int n = 0;
    i_wr_req  = 1'b1;
    i_wr_addr = a;
    i_wr_data = d;
    wr_q.push_back('{a, d});
    do begin
      @(negedge i_clk);
      n++;
      if (!o_sram_we_n && drop_early) i_wr_req = 1'b0;
      if (scramble && !o_sram_we_n) begin
        i_wr_addr = ~a;
        i_wr_data = ~d;
      end
    end while (!o_wr_ack && n < 100);
    chk("wr_ack_seen", o_wr_ack, 1'b1);
    if (!hold) i_wr_req = 1'b0;
    lat = n;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp_d,
                         input bit drop_early, input bit hold, output int lat);
    int n = 0;
    i_rd_req  = 1'b1;
    i_rd_addr = a;
    rd_q.push_back('{a, exp_d});
    do begin
      @(negedge i_clk);
      n++;
      if (!o_sram_oe_n && drop_early) i_rd_req = 1'b0;
    end while (!o_rd_valid && n < 100);
    chk("rd_valid_seen", o_rd_valid, 1'b1);
    if (!hold) i_rd_req = 1'b0;
    lat = n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int snap_wg, snap_wa, snap_rg, snap_rv, ack_before;
    logic [7:0] ra;

    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    chk("rst_we_n", o_sram_we_n, 1'b1);
    chk("rst_oe_n", o_sram_oe_n, 1'b1);
    chk("rst_ce_lb_ub", {o_sram_ce_n, o_sram_lb_n, o_sram_ub_n}, 3'b000);
    chk("rst_dq_oe", o_sram_dq_oe, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_ack_valid", {o_wr_ack, o_rd_valid}, 2'b00);
    chk("rst_rd_data", o_rd_data, 16'h0000);
    chk("rst_addr_dq", {o_sram_addr, o_sram_dq_out}, 36'h0);

    // Single write then read back, inputs scrambled after grant
    @(negedge i_clk);
    do_write(20'h00012, 16'hBEEF, 1'b0, 1'b1, 1'b0, lat);
    chk("wr_latency", lat, WR_CYC + 1);
    @(negedge i_clk);
    do_read(20'h00012, 16'hBEEF, 1'b0, 1'b0, lat);
    chk("rd_latency", lat, RD_WAIT + 1);
    chk("rd_data_beef", o_rd_data, 16'hBEEF);
    repeat (3) @(negedge i_clk);
    chk("rd_data_held", o_rd_data, 16'hBEEF);

    // Contention: last grant was read, so W,R,W,R,W,R
    grant_log.delete();
    fork
      begin
        int l;
        for (int i = 0; i < 3; i++)
          do_write(20'h00080 + ADDR_W'(i), 16'hA000 + 16'(i), 1'b0, 1'b0, i < 2, l);
      end
      begin
        int l;
        for (int i = 0; i < 3; i++)
          do_read(20'h00020 + ADDR_W'(i), pat(8'h20 + 8'(i)), 1'b0, i < 2, l);
      end
    join
    repeat (2) @(negedge i_clk);
    chk("rr_grant_count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      chk($sformatf("rr_grant_%0d", i), grant_log[i], (i % 2) == 0);

    // Reset during first write strobe cycle aborts the access
    @(negedge i_clk);
    i_wr_req  = 1'b1;
    i_wr_addr = 20'h00090;
    i_wr_data = 16'h1234;
    wr_q.push_back('{20'h00090, 16'h1234});
    for (int i = 0; i < 20 && o_sram_we_n; i++) @(negedge i_clk);
    chk("abort_in_wr", o_sram_we_n, 1'b0);
    ack_before = n_wr_ack;
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("abort_we_n", o_sram_we_n, 1'b1);
    chk("abort_dq_oe", o_sram_dq_oe, 1'b0);
    chk("abort_busy", o_busy, 1'b0);
    i_rst    = 1'b0;
    i_wr_req = 1'b0;
    wr_q.delete();
    repeat (10) @(negedge i_clk);
    chk("abort_no_ack", n_wr_ack - ack_before, 0);

    // Five writes and three reads after reset
    for (int i = 0; i < 5; i++) begin
      do_write(20'h000A0 + ADDR_W'(i), 16'h5000 + 16'(i), 1'b0, 1'b0, 1'b0, lat);
      @(negedge i_clk);
    end
    for (int i = 0; i < 3; i++) begin
      do_read(20'h000A0 + ADDR_W'(i), 16'h5000 + 16'(i), 1'b0, 1'b0, lat);
      @(negedge i_clk);
    end
`ifdef SRAM_ARB_STATS_EN
    chk("wr_count_5", o_wr_count, 16'd5);
    chk("rd_count_3", o_rd_count, 16'd3);
`endif

    // Random traffic on both ports
    snap_wg = n_wr_grant; snap_wa = n_wr_ack;
    snap_rg = n_rd_grant; snap_rv = n_rd_valid;
    fork
      begin
        int l;
        for (int i = 0; i < 80; i++) begin
          repeat ($urandom_range(0, 5)) @(negedge i_clk);
          do_write(20'h00080 + ADDR_W'($urandom_range(0, 15)), 16'($urandom),
                   $urandom_range(0, 3) == 0, 1'b0, 1'b0, l);
        end
      end
      begin
        int l;
        for (int i = 0; i < 80; i++) begin
          repeat ($urandom_range(0, 5)) @(negedge i_clk);
          ra = 8'($urandom_range(8'h20, 8'h7F));
          do_read({12'h000, ra}, pat(ra), $urandom_range(0, 3) == 0, 1'b0, l);
        end
      end
    join
    repeat (4) @(negedge i_clk);
    chk("rand_wr_ack_eq_grant", n_wr_ack - snap_wa, n_wr_grant - snap_wg);
    chk("rand_rd_valid_eq_grant", n_rd_valid - snap_rv, n_rd_grant - snap_rg);
    chk("rand_wr_done", n_wr_ack - snap_wa, 80);
    chk("rand_rd_done", n_rd_valid - snap_rv, 80);
    chk("idle_at_end", o_busy, 1'b0);
`ifdef SRAM_ARB_STATS_EN
    chk("wr_count_total", o_wr_count, 16'd85);
    chk("rd_count_total", o_rd_count, 16'd83);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
